// File: rtl/soc_sim_pkg.sv
// Shared types and default constants for the SoC simulation/test-status monitor.
package soc_sim_pkg;

  typedef enum logic [2:0] {
    ST_RUNNING      = 3'd0,
    ST_PASS         = 3'd1,
    ST_FAIL_MAGIC   = 3'd2,
    ST_FAIL_WDOG    = 3'd3,
    ST_FAIL_TIMEOUT = 3'd4
  } test_status_e;

  localparam logic [31:0] PUTC_ADDR_DEF   = 32'h01FF_FFF0;
  localparam logic [63:0] PASS_MAGIC_DEF  = 64'h0000_0004_4433_3222;
  localparam logic [63:0] FAIL_MAGIC_DEF  = 64'h0000_0023_8234_8720;
  localparam int unsigned WDOG_PERIOD_DEF = 50000;
  localparam logic [31:0] MAX_CYCLES_DEF  = 32'h0300_0000;

  typedef struct packed {
    logic       hit;
    logic [7:0] ch;
  } putc_t;

  // Only a single full 32-bit lane strobe selects a character; partial or mixed strobes do not.
  function automatic putc_t putc_lane(input logic [15:0] strb, input logic [127:0] data);
    putc_t r;
    r.hit = 1'b0;
    r.ch  = '0;
    case (strb)
      16'h000F: begin r.hit = 1'b1; r.ch = data[7:0];   end
      16'h00F0: begin r.hit = 1'b1; r.ch = data[39:32]; end
      16'h0F00: begin r.hit = 1'b1; r.ch = data[71:64]; end
      16'hF000: begin r.hit = 1'b1; r.ch = data[103:96]; end
      default:  ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/soc_sim_wdog.sv
// Retire-activity watchdog: window down-counter plus per-window retire cycle counter.
module soc_sim_wdog
  import soc_sim_pkg::*;
#(
  parameter int unsigned WDOG_PERIOD = WDOG_PERIOD_DEF
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        en,
  input  logic [2:0]  retire_vld,
  output logic        wdog_fail,
  output logic [31:0] retire_cnt
);

  // win_left == 0 marks the cycle whose window count is a multiple of WDOG_PERIOD;
  // after reset the window count is 1, i.e. WDOG_PERIOD-1 cycles remain.
  localparam logic [31:0] RELOAD = 32'(WDOG_PERIOD - 1);

  logic [31:0] win_left;
  logic        boundary;

  assign boundary  = (win_left == '0);
  assign wdog_fail = en && boundary && (retire_cnt == '0);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      win_left   <= RELOAD;
      retire_cnt <= '0;
    end else if (en) begin
      if (boundary) begin
        win_left   <= RELOAD;
        retire_cnt <= '0;
      end else begin
        win_left <= win_left - 32'd1;
        if ((|retire_vld) && (retire_cnt != '1))
          retire_cnt <= retire_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/soc_sim_monitor.sv
// SoC test-status monitor: putchar decode, pass/fail magic detection, watchdog and timeout.
module soc_sim_monitor
  import soc_sim_pkg::*;
#(
  parameter logic [31:0] PUTC_ADDR   = PUTC_ADDR_DEF,
  parameter logic [63:0] PASS_MAGIC  = PASS_MAGIC_DEF,
  parameter logic [63:0] FAIL_MAGIC  = FAIL_MAGIC_DEF,
  parameter int unsigned WDOG_PERIOD = WDOG_PERIOD_DEF,
  parameter logic [31:0] MAX_CYCLES  = MAX_CYCLES_DEF
) (
  input  logic         i_pad_clk,
  input  logic         i_pad_rst_b,
  input  logic         clk_en,
  input  logic [3:0]   aw_len,
  input  logic [31:0]  mem_addr,
  input  logic         w_valid,
  input  logic [15:0]  w_strb,
  input  logic [127:0] w_data,
  input  logic [2:0]   retire_vld,
  input  logic [63:0]  wb_data0,
  input  logic [63:0]  wb_data1,
  input  logic [63:0]  wb_data2,
  output logic         char_vld,
  output logic [7:0]   char_data,
  output logic         test_done,
  output logic [2:0]   test_status,
  output logic [31:0]  retire_cnt
);

  logic         clk_en_q;
  logic [3:0]   aw_len_q;
  logic [31:0]  mem_addr_q;
  logic         w_valid_q;
  logic [15:0]  w_strb_q;
  logic [127:0] w_data_q;
  logic [63:0]  wb_data0_q;
  logic [63:0]  wb_data1_q;
  logic [63:0]  wb_data2_q;

  always_ff @(posedge i_pad_clk or negedge i_pad_rst_b) begin
    if (!i_pad_rst_b) begin
      clk_en_q   <= 1'b0;
      aw_len_q   <= '0;
      mem_addr_q <= '0;
      w_valid_q  <= 1'b0;
      w_strb_q   <= '0;
      w_data_q   <= '0;
      wb_data0_q <= '0;
      wb_data1_q <= '0;
      wb_data2_q <= '0;
    end else begin
      clk_en_q   <= clk_en;
      aw_len_q   <= aw_len;
      mem_addr_q <= mem_addr;
      w_valid_q  <= w_valid;
      w_strb_q   <= w_strb;
      w_data_q   <= w_data;
      wb_data0_q <= wb_data0;
      wb_data1_q <= wb_data1;
      wb_data2_q <= wb_data2;
    end
  end

  test_status_e state_q, state_d;
  logic         running;
  logic         pass_hit, fail_hit;
  logic         putc_addr_ok;
  putc_t        putc;
  logic         char_vld_d;
  logic         wdog_fail;
  logic         timeout_hit;
  logic [31:0]  cyc_cnt;

  assign running = (state_q == ST_RUNNING);

  assign pass_hit = (wb_data0_q == PASS_MAGIC) || (wb_data1_q == PASS_MAGIC) ||
                    (wb_data2_q == PASS_MAGIC);
  assign fail_hit = (wb_data0_q == FAIL_MAGIC) || (wb_data1_q == FAIL_MAGIC) ||
                    (wb_data2_q == FAIL_MAGIC);

  assign putc_addr_ok = (aw_len_q == 4'd0) && (mem_addr_q == PUTC_ADDR) && w_valid_q && clk_en_q;
  assign putc         = putc_lane(w_strb_q, w_data_q);

  // cyc_cnt holds the edges already taken, so this edge's 1-based count exceeds
  // MAX_CYCLES exactly when cyc_cnt >= MAX_CYCLES.
  assign timeout_hit = (cyc_cnt >= MAX_CYCLES);

  always_ff @(posedge i_pad_clk or negedge i_pad_rst_b) begin
    if (!i_pad_rst_b)
      cyc_cnt <= '0;
    else if (running && (cyc_cnt != '1))
      cyc_cnt <= cyc_cnt + 32'd1;
  end

  soc_sim_wdog #(
    .WDOG_PERIOD (WDOG_PERIOD)
  ) u_wdog (
    .clk        (i_pad_clk),
    .rst_b      (i_pad_rst_b),
    .en         (running),
    .retire_vld (retire_vld),
    .wdog_fail  (wdog_fail),
    .retire_cnt (retire_cnt)
  );

  always_comb begin
    state_d    = state_q;
    char_vld_d = 1'b0;
    if (running) begin
      if (pass_hit)
        state_d = ST_PASS;
      else if (fail_hit)
        state_d = ST_FAIL_MAGIC;
      else if (wdog_fail)
        state_d = ST_FAIL_WDOG;
      else if (timeout_hit)
        state_d = ST_FAIL_TIMEOUT;
      char_vld_d = !pass_hit && !fail_hit && putc_addr_ok && putc.hit;
    end
  end

  always_ff @(posedge i_pad_clk or negedge i_pad_rst_b) begin
    if (!i_pad_rst_b) begin
      state_q   <= ST_RUNNING;
      char_vld  <= 1'b0;
      char_data <= '0;
    end else begin
      state_q  <= state_d;
      char_vld <= char_vld_d;
      if (char_vld_d)
        char_data <= putc.ch;
    end
  end

  assign test_status = state_q;
  assign test_done   = !running;

endmodule

// File: tb/tb_soc_sim_monitor.sv
// Directed self-checking bench for soc_sim_monitor (main instance plus a short-timeout instance).
module tb_soc_sim_monitor;

  localparam logic [31:0] PUTC = 32'h01FF_FFF0;
  localparam logic [63:0] PASS = 64'h0000_0004_4433_3222;
  localparam logic [63:0] FAIL = 64'h0000_0023_8234_8720;

  logic         clk = 1'b0;
  logic         rst_a, rst_t;
  logic         clk_en;
  logic [3:0]   aw_len;
  logic [31:0]  mem_addr;
  logic         w_valid;
  logic [15:0]  w_strb;
  logic [127:0] w_data;
  logic [2:0]   retire_vld;
  logic [63:0]  wb_data0, wb_data1, wb_data2;

  logic         cv_a, cv_t;
  logic [7:0]   cd_a, cd_t;
  logic         done_a, done_t;
  logic [2:0]   st_a, st_t;
  logic [31:0]  rc_a, rc_t;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  soc_sim_monitor #(
    .WDOG_PERIOD (100)
  ) dut_a (
    .i_pad_clk (clk), .i_pad_rst_b (rst_a), .clk_en (clk_en), .aw_len (aw_len),
    .mem_addr (mem_addr), .w_valid (w_valid), .w_strb (w_strb), .w_data (w_data),
    .retire_vld (retire_vld), .wb_data0 (wb_data0), .wb_data1 (wb_data1), .wb_data2 (wb_data2),
    .char_vld (cv_a), .char_data (cd_a), .test_done (done_a), .test_status (st_a),
    .retire_cnt (rc_a)
  );

  soc_sim_monitor #(
    .WDOG_PERIOD (100),
    .MAX_CYCLES  (32'd200)
  ) dut_t (
    .i_pad_clk (clk), .i_pad_rst_b (rst_t), .clk_en (clk_en), .aw_len (aw_len),
    .mem_addr (mem_addr), .w_valid (w_valid), .w_strb (w_strb), .w_data (w_data),
    .retire_vld (retire_vld), .wb_data0 (wb_data0), .wb_data1 (wb_data1), .wb_data2 (wb_data2),
    .char_vld (cv_t), .char_data (cd_t), .test_done (done_t), .test_status (st_t),
    .retire_cnt (rc_t)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    clk_en = 1'b0; aw_len = '0; mem_addr = '0; w_valid = 1'b0; w_strb = '0;
    w_data = '0; wb_data0 = '0; wb_data1 = '0; wb_data2 = '0;
  endtask

  task automatic send_write(input logic [31:0] a, input logic [3:0] len, input logic [15:0] strb,
                            input logic [127:0] d, input logic v, input logic ce);
    mem_addr = a; aw_len = len; w_strb = strb; w_data = d; w_valid = v; clk_en = ce;
    step(1);
    clear_inputs();
    step(1);
  endtask

  task automatic reset_a();
    rst_a = 1'b0;
    clear_inputs();
    retire_vld = '0;
    #2;
    step(1);
    rst_a = 1'b1;
  endtask

  logic [127:0] d;

  initial begin
    rst_a = 1'b0;
    rst_t = 1'b0;
    retire_vld = '0;
    clear_inputs();
    step(2);

    chk("rst_char_vld", {31'd0, cv_a}, 32'd0);
    chk("rst_char_data", {24'd0, cd_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_status", {29'd0, st_a}, 32'd0);
    chk("rst_retire_cnt", rc_a, 32'd0);
    rst_a = 1'b1;

    // putchar lanes, with non-selected lanes holding filler bytes
    d = {16{8'hEE}}; d[39:32] = 8'h41;
    send_write(PUTC, 4'd0, 16'h00F0, d, 1'b1, 1'b1);
    chk("putc_A_vld", {31'd0, cv_a}, 32'd1);
    chk("putc_A_data", {24'd0, cd_a}, 32'h41);
    step(1);
    chk("putc_A_one_cycle", {31'd0, cv_a}, 32'd0);

    send_write(PUTC, 4'd0, 16'h00FF, d, 1'b1, 1'b1);
    chk("putc_strb_ff_none", {31'd0, cv_a}, 32'd0);

    d = {16{8'hEE}}; d[7:0] = 8'h5A;
    send_write(PUTC, 4'd0, 16'h000F, d, 1'b1, 1'b1);
    chk("putc_l0_vld", {31'd0, cv_a}, 32'd1);
    chk("putc_l0_data", {24'd0, cd_a}, 32'h5A);

    d = {16{8'hEE}}; d[71:64] = 8'h33;
    send_write(PUTC, 4'd0, 16'h0F00, d, 1'b1, 1'b1);
    chk("putc_l2_vld", {31'd0, cv_a}, 32'd1);
    chk("putc_l2_data", {24'd0, cd_a}, 32'h33);

    d = {16{8'hEE}}; d[103:96] = 8'h7E;
    send_write(PUTC, 4'd0, 16'hF000, d, 1'b1, 1'b1);
    chk("putc_l3_vld", {31'd0, cv_a}, 32'd1);
    chk("putc_l3_data", {24'd0, cd_a}, 32'h7E);

    send_write(PUTC + 32'd4, 4'd0, 16'hF000, d, 1'b1, 1'b1);
    chk("putc_bad_addr", {31'd0, cv_a}, 32'd0);
    send_write(PUTC, 4'd1, 16'hF000, d, 1'b1, 1'b1);
    chk("putc_len1", {31'd0, cv_a}, 32'd0);
    send_write(PUTC, 4'd0, 16'hF000, d, 1'b0, 1'b1);
    chk("putc_no_valid", {31'd0, cv_a}, 32'd0);
    send_write(PUTC, 4'd0, 16'hF000, d, 1'b1, 1'b0);
    chk("putc_no_clken", {31'd0, cv_a}, 32'd0);
    chk("putc_still_running", {29'd0, st_a}, 32'd0);

    // putchar and PASS in the same sample: PASS wins, no character
    mem_addr = PUTC; aw_len = 4'd0; w_strb = 16'hF000; w_data = d; w_valid = 1'b1; clk_en = 1'b1;
    wb_data1 = PASS;
    step(1);
    chk("pass_lat1_status", {29'd0, st_a}, 32'd0);
    clear_inputs();
    step(1);
    chk("pass_status", {29'd0, st_a}, 32'd1);
    chk("pass_done", {31'd0, done_a}, 32'd1);
    chk("pass_suppresses_char", {31'd0, cv_a}, 32'd0);
    wb_data0 = FAIL;
    step(1);
    clear_inputs();
    step(2);
    chk("pass_held_after_fail", {29'd0, st_a}, 32'd1);
    d = {16{8'hEE}}; d[7:0] = 8'h42;
    send_write(PUTC, 4'd0, 16'h000F, d, 1'b1, 1'b1);
    chk("done_blocks_char", {31'd0, cv_a}, 32'd0);

    // async reset mid-run clears immediately
    rst_a = 1'b0;
    #2;
    chk("async_rst_done", {31'd0, done_a}, 32'd0);
    chk("async_rst_status", {29'd0, st_a}, 32'd0);
    step(1);
    rst_a = 1'b1;

    wb_data2 = FAIL;
    step(1);
    clear_inputs();
    step(1);
    chk("fail_magic_status", {29'd0, st_a}, 32'd2);
    chk("fail_magic_done", {31'd0, done_a}, 32'd1);

    reset_a();
    wb_data2 = FAIL; wb_data0 = PASS;
    step(1);
    clear_inputs();
    step(1);
    chk("pass_over_fail", {29'd0, st_a}, 32'd1);

    // watchdog with no retire: boundary is the 100th edge after reset
    reset_a();
    step(99);
    chk("wdog_pre_boundary", {29'd0, st_a}, 32'd0);
    step(1);
    chk("wdog_fail_status", {29'd0, st_a}, 32'd3);
    chk("wdog_fail_done", {31'd0, done_a}, 32'd1);

    // one retire burst per window keeps it alive; multi-slot counts once per cycle
    reset_a();
    step(49);
    retire_vld = 3'b111;
    step(2);
    retire_vld = '0;
    chk("retire_cnt_two", rc_a, 32'd2);
    step(48);
    chk("retire_pre_boundary", rc_a, 32'd2);
    step(1);
    chk("retire_cleared", rc_a, 32'd0);
    chk("retire_alive", {29'd0, st_a}, 32'd0);
    step(99);
    retire_vld = 3'b100;
    step(1);
    chk("boundary_beats_retire", {29'd0, st_a}, 32'd3);
    chk("boundary_retire_uncounted", rc_a, 32'd0);
    step(2);
    chk("retire_frozen", rc_a, 32'd0);
    retire_vld = '0;

    reset_a();
    retire_vld = 3'b001;
    step(5);
    retire_vld = '0;
    chk("retire_cnt_five", rc_a, 32'd5);
    rst_a = 1'b0;
    #2;
    chk("async_rst_retire_cnt", rc_a, 32'd0);
    step(1);
    rst_a = 1'b1;

    // timeout instance: steady retire, limit 200
    retire_vld = 3'b001;
    rst_t = 1'b1;
    step(200);
    chk("timeout_pre", {29'd0, st_t}, 32'd0);
    step(1);
    chk("timeout_status", {29'd0, st_t}, 32'd4);
    chk("timeout_done", {31'd0, done_t}, 32'd1);
    step(3);
    chk("timeout_retire_frozen", rc_t, 32'd1);
    chk("timeout_held", {29'd0, st_t}, 32'd4);

    rst_t = 1'b0;
    #2;
    chk("t_rst_status", {29'd0, st_t}, 32'd0);
    chk("t_rst_done", {31'd0, done_t}, 32'd0);
    chk("t_rst_retire_cnt", rc_t, 32'd0);
    chk("t_rst_char_vld", {31'd0, cv_t}, 32'd0);
    chk("t_rst_char_data", {24'd0, cd_t}, 32'd0);
    step(1);
    rst_t = 1'b1;
    step(200);
    chk("timeout_restart_pre", {29'd0, st_t}, 32'd0);
    step(1);
    chk("timeout_restart", {29'd0, st_t}, 32'd4);
    retire_vld = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
